cu_fsm: RTL
===========

CU_FSM -- requirements
Module: cu_fsm

Interface
REQ-001 Parameter: INIT_CYCLES, default 1 (legal 1..15), number of cycles the INIT state holds rst_pc high.
REQ-002 clk  in  1  rising-edge system clock; single clock domain.
REQ-003 rst_n  in  1  reset; asynchronous, active-low.
REQ-004 opcode  in  7  instruction bits [6:0] from the instruction register.
REQ-005 funct3  in  3  instruction bits [14:12].
REQ-006 intr  in  1  interrupt request, synchronous to clk, already gated by MIE outside this block.
REQ-007 mem_ready  in  1  data-memory read complete.
REQ-008 pc_write  out  1  PC register load enable.
REQ-009 reg_write  out  1  register-file write enable.
REQ-010 mem_rden1  out  1  instruction-memory read enable.
REQ-011 mem_rden2  out  1  data-memory read enable.
REQ-012 mem_we2  out  1  data-memory write enable.
REQ-013 rst_pc  out  1  PC synchronous reset.
REQ-014 csr_we  out  1  CSR write enable.
REQ-015 int_taken  out  1  interrupt-entry strobe (PC to mtvec, save mepc).
REQ-016 mret_exec  out  1  MRET strobe (PC to mepc).
REQ-017 fsm_state  out  3  current state encoding, for debug and verification.

Function
REQ-018 The block SHALL have five states, with these encodings: INIT=0, FETCH=1, EXEC=2, WB=3, INTR=4.
REQ-019 All outputs SHALL be combinational from state, opcode, funct3 and mem_ready; any output not listed for a state SHALL be 0.
REQ-020 INIT: rst_pc=1; the 4-bit counter increments each cycle; the state SHALL move to FETCH on the edge where the counter reaches INIT_CYCLES-1.
REQ-021 FETCH: mem_rden1=1; the state SHALL always move to EXEC after exactly one cycle.
REQ-022 EXEC, LOAD (0000011): mem_rden2=1, pc_write=0; next state WB.
REQ-023 EXEC, STORE (0100011): mem_we2=1, pc_write=1.
REQ-024 EXEC, BRANCH (1100011): pc_write=1, reg_write=0.
REQ-025 EXEC, LUI/AUIPC/JAL/JALR/OP-IMM/OP (0110111/0010111/1101111/1100111/0010011/0110011): pc_write=1, reg_write=1.
REQ-026 EXEC, SYSTEM (1110011): if funct3=001 then csr_we=1, reg_write=1, pc_write=1; if funct3=000 then mret_exec=1, pc_write=1; any other funct3 is treated as a NOP.
REQ-027 EXEC, any other opcode: NOP with pc_write=1 only; no trap is raised.
REQ-028 WB with mem_ready=0: mem_rden2=1, and the state SHALL hold in WB with no cap on wait length.
REQ-029 WB with mem_ready=1: reg_write=1, pc_write=1; the instruction completes.
REQ-030 intr SHALL be sampled only on the completing edge (non-LOAD EXEC, or WB with mem_ready=1): intr=1 gives next state INTR, otherwise FETCH.
REQ-031 intr SHALL be ignored in INIT, FETCH, INTR, LOAD-EXEC and in WB while mem_ready=0.
REQ-032 INTR: int_taken=1, pc_write=1, for exactly one cycle; next state FETCH, independent of intr.
REQ-033 If intr is asserted in the same cycle as MRET completes, the MRET SHALL complete and the next state SHALL be INTR.
REQ-034 Latency: non-load instructions SHALL take 2 cycles; loads SHALL take 3+N cycles, where N is the number of WB cycles with mem_ready=0; an interrupt SHALL add 1 cycle.

Reset
REQ-035 While rst_n=0, state=INIT and counter=0, asynchronously: rst_pc=1, all other outputs 0, fsm_state=0.
REQ-036 Reset asserted mid-operation (any state) SHALL abort immediately with no write strobes; counting SHALL restart on the first clk edge after release.

Configuration
REQ-037 Macro CU_FSM_INTR_EN defined: INTR state, intr sampling and int_taken are implemented as specified above.
REQ-038 Macro CU_FSM_INTR_EN undefined: intr is ignored, completion always goes to FETCH, int_taken is tied 0, and encoding 4 is unreachable; MRET and CSRRW behaviour is unchanged.

Verification
REQ-039 INIT_CYCLES=3, release rst_n -> rst_pc=1 for 3 cycles, then fsm_state=1 with mem_rden1=1.
REQ-040 opcode=0010011, intr=0 -> EXEC gives pc_write=1, reg_write=1; FETCH follows; 2 cycles per instruction.
REQ-041 opcode=0000011, mem_ready=0 for 2 WB cycles then 1 -> EXEC gives mem_rden2=1; WB holds 2 cycles with reg_write=0; 3rd WB cycle gives reg_write=1, pc_write=1; then FETCH.
REQ-042 opcode=1100011 with intr=1 in EXEC -> INTR next (int_taken=1, pc_write=1), then FETCH; with CU_FSM_INTR_EN undefined -> FETCH next and int_taken never 1.
REQ-043 opcode=1110011: funct3=001 -> csr_we=1, reg_write=1; funct3=000 with intr=1 -> mret_exec=1, then INTR.
REQ-044 rst_n=0 during WB -> fsm_state=0, reg_write=0 and rst_pc=1 before the next clk edge.

Source files
------------

// File: rtl/cu_fsm.sv
// ============================================================================
// Module   : cu_fsm
// Brief    : Multi-cycle RISC-V control unit FSM (INIT/FETCH/EXEC/WB/INTR).
//            Optional interrupt support enabled by macro CU_FSM_INTR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cu_fsm #(
    parameter int INIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       intr,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_rden1,
    output logic       mem_rden2,
    output logic       mem_we2,
    output logic       rst_pc,
    output logic       csr_we,
    output logic       int_taken,
    output logic       mret_exec,
    output logic [2:0] fsm_state
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_WB    = 3'd3,
        S_INTR  = 3'd4
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done      = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        mem_rden1 = 1'b0;
        mem_rden2 = 1'b0;
        mem_we2   = 1'b0;
        rst_pc    = 1'b0;
        csr_we    = 1'b0;
        int_taken = 1'b0;
        mret_exec = 1'b0;

        case (state_q)
            S_INIT: begin
                rst_pc = 1'b1;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == INIT_LAST) begin
                    state_d = S_FETCH;
                    cnt_d   = 4'd0;
                end
            end
            S_FETCH: begin
                mem_rden1 = 1'b1;
                state_d   = S_EXEC;
            end
            S_EXEC: begin
                case (opcode)
                    OP_LOAD: begin
                        mem_rden2 = 1'b1;
                        state_d   = S_WB;
                    end
                    OP_STORE: begin
                        mem_we2  = 1'b1;
                        pc_write = 1'b1;
                        done     = 1'b1;
                    end
                    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_OP: begin
                        pc_write  = 1'b1;
                        reg_write = 1'b1;
                        done      = 1'b1;
                    end
                    OP_SYSTEM: begin
                        pc_write = 1'b1;
                        done     = 1'b1;
                        if (funct3 == 3'b001) begin
                            csr_we    = 1'b1;
                            reg_write = 1'b1;
                        end else if (funct3 == 3'b000) begin
                            mret_exec = 1'b1;
                        end
                    end
                    // BRANCH and unknown opcodes just advance the PC
                    default: begin
                        pc_write = 1'b1;
                        done     = 1'b1;
                    end
                endcase
            end
            S_WB: begin
                if (mem_ready) begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    done      = 1'b1;
                end else begin
                    mem_rden2 = 1'b1;
                end
            end
`ifdef CU_FSM_INTR_EN
            S_INTR: begin
                int_taken = 1'b1;
                pc_write  = 1'b1;
                state_d   = S_FETCH;
            end
`endif
            default: state_d = S_FETCH;
        endcase

        // intr is only looked at on the edge that retires an instruction
        if (done) begin
`ifdef CU_FSM_INTR_EN
            state_d = intr ? S_INTR : S_FETCH;
`else
            state_d = S_FETCH;
`endif
        end
    end

`ifndef CU_FSM_INTR_EN
    logic unused_intr;
    assign unused_intr = intr;
`endif

    assign fsm_state = state_q;

endmodule

`default_nettype wire
